// File: rtl/fetch_pkg.sv
// Shared types for the front-end fetch stage: FSM encoding, queue entry layout, word size.
package fetch_pkg;

   localparam int INSTR_BYTES   = 4;
   localparam int FETCH_ADDR_W  = 32;
   localparam int FETCH_INSTR_W = 32;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   // Entry layout pushed into the instruction queue; PC occupies the MSBs.
   typedef struct packed {
      logic [FETCH_ADDR_W-1:0]  pc;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry staging register between the icache response and the instruction queue.
module fetch_hold_buf
   import fetch_pkg::*;
#(
   parameter int WIDTH = FETCH_ADDR_W + FETCH_INSTR_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             drain_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // Flush wins over a same-cycle load; a load refills over a same-cycle drain.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (drain_i) valid_d = 1'b0;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
      if (flush_i) valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// PC generation and single-outstanding instruction fetch; pairs each response with its PC
// and hands {pc, instr} to the instruction queue. Redirects re-steer and squash in-flight work.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   output logic                              icache_req_valid,
   input  logic                              icache_req_ready,
   output logic [ADDR_WIDTH-1:0]             icache_req_addr,
   input  logic                              icache_resp_valid,
   input  logic [INSTR_WIDTH-1:0]            icache_resp_instr,
   input  logic                              redirect_valid,
   input  logic [ADDR_WIDTH-1:0]             redirect_pc,
   output logic                              valid_enq,
   input  logic                              ready_enq,
   output logic [ADDR_WIDTH+INSTR_WIDTH-1:0] data_enq
);

   localparam int                    EW         = ADDR_WIDTH + INSTR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(INSTR_BYTES);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                  hold_valid;
   logic [EW-1:0]         hold_data;
   logic                  req_vld, req_fire, drain, load;

   // A new request may go out only if its response will find the hold slot free.
   assign req_vld  = (state_q == REQ) && (!hold_valid || ready_enq);
   assign req_fire = req_vld && icache_req_ready;
   assign drain    = hold_valid && ready_enq;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      load    = 1'b0;
      if (redirect_valid) begin
         pc_d = redirect_pc & ALIGN_MASK;
         case (state_q)
            REQ:        state_d = req_fire ? DROP : REQ;
            WAIT, DROP: state_d = icache_resp_valid ? REQ : DROP;
            default:    state_d = REQ;
         endcase
      end else begin
         case (state_q)
            REQ:  if (req_fire) state_d = WAIT;
            WAIT: if (icache_resp_valid) begin
                     load    = 1'b1;
                     pc_d    = pc_q + PC_STEP;
                     state_d = REQ;
                  end
            DROP: if (icache_resp_valid) state_d = REQ;
            default: state_d = REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_hold_buf #(.WIDTH(EW)) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .drain_i (drain),
      .flush_i (redirect_valid),
      .data_i  ({pc_q, icache_resp_instr}),
      .valid_o (hold_valid),
      .data_o  (hold_data)
   );

   // Outputs are forced quiet while reset is held, before the synchronous reset lands.
   assign icache_req_valid = req_vld && !rst;
   assign icache_req_addr  = rst ? RESET_PC : pc_q;
   assign valid_enq        = hold_valid && !rst;
   assign data_enq         = rst ? '0 : hold_data;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus scripted redirect/reset sequences,
// with a scoreboard of expected request addresses and enqueued entries.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic        clk;
   logic        rst, icache_req_ready, ready_enq, redirect_valid;
   logic [31:0] redirect_pc;
   logic        icache_resp_valid;
   logic [31:0] icache_resp_instr;
   logic        req_valid, valid_enq, b_req_valid, b_valid_enq;
   logic [31:0] req_addr, b_req_addr;
   logic [63:0] data_enq, b_data_enq;

   logic        mem_auto, man_v, auto_v;
   logic [31:0] man_instr, auto_instr;

   int           n_vec = 0;
   int           n_bad = 0;
   logic [31:0]  exp_addr_q[$];
   fetch_entry_t exp_enq_q[$];
   logic [31:0]  b_q[$];
   bit           b_cap = 0;

   typedef struct {
      bit           rdy;
      bit           rv;
      logic [31:0]  addr;
      bit           ve;
      fetch_entry_t data;
   } vec_t;
   vec_t tbl[8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign icache_resp_valid = mem_auto ? auto_v : man_v;
   assign icache_resp_instr = mem_auto ? auto_instr : man_instr;

   fetch_unit dut (
      .clk(clk), .rst(rst),
      .icache_req_valid(req_valid), .icache_req_ready(icache_req_ready), .icache_req_addr(req_addr),
      .icache_resp_valid(icache_resp_valid), .icache_resp_instr(icache_resp_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .valid_enq(valid_enq), .ready_enq(ready_enq), .data_enq(data_enq)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
      .clk(clk), .rst(rst),
      .icache_req_valid(b_req_valid), .icache_req_ready(icache_req_ready), .icache_req_addr(b_req_addr),
      .icache_resp_valid(icache_resp_valid), .icache_resp_instr(icache_resp_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .valid_enq(b_valid_enq), .ready_enq(ready_enq), .data_enq(b_data_enq)
   );

   function automatic logic [31:0] f(input logic [31:0] a);
      return {a[23:0], 8'h13};
   endfunction

   function automatic fetch_entry_t ent(input logic [31:0] pc);
      fetch_entry_t e;
      e.pc    = pc;
      e.instr = f(pc);
      return e;
   endfunction

   function automatic vec_t mkv(input bit rdy, input bit rv, input logic [31:0] addr,
                                input bit ve, input logic [31:0] pc);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.addr = addr; v.ve = ve; v.data = ent(pc);
      return v;
   endfunction

   // Auto memory: answers one cycle after each accepted request.
   initial begin
      logic        acc;
      logic [31:0] a;
      auto_v = 1'b0;
      auto_instr = '0;
      forever begin
         @(negedge clk);
         acc = req_valid && icache_req_ready && !rst;
         a   = req_addr;
         @(posedge clk);
         #1;
         auto_v     = acc;
         auto_instr = acc ? f(a) : '0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic sample();
      if (!rst) begin
         if (req_valid && icache_req_ready) begin
            if (exp_addr_q.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL extra_req: got addr %h want no request", req_addr);
            end else chk("sb_req_addr", 64'(req_addr), 64'(exp_addr_q.pop_front()));
         end
         if (valid_enq && ready_enq) begin
            if (exp_enq_q.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL extra_enq: got %h want no enqueue", data_enq);
            end else chk("sb_enq_data", data_enq, 64'(exp_enq_q.pop_front()));
         end
         if (b_cap && b_req_valid && icache_req_ready) b_q.push_back(b_req_addr);
      end
   endtask

   task automatic smp();
      @(negedge clk);
      sample();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drained();
      chk("sb_addr_left", 64'(exp_addr_q.size()), 64'd0);
      chk("sb_enq_left", 64'(exp_enq_q.size()), 64'd0);
      exp_addr_q.delete();
      exp_enq_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; ready_enq = 1'b1; icache_req_ready = 1'b1;
      redirect_valid = 1'b0; redirect_pc = '0;
      mem_auto = 1'b1; man_v = 1'b0; man_instr = '0;
      smp();
      tick();
      smp();
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_valid_enq", 64'(valid_enq), 64'd0);
      chk("rst_data_enq", data_enq, 64'd0);
      chk("rst_req_addr", 64'(req_addr), 64'd0);
      chk("rst_b_req_addr", 64'(b_req_addr), 64'hFFFF_FFFC);
      tick();
      rst = 1'b0;
   endtask

   task automatic cyc_chk(input string tag, input bit rv, input logic [31:0] addr,
                          input bit ve, input logic [31:0] pc);
      smp();
      chk({tag, "_req_valid"}, 64'(req_valid), 64'(rv));
      if (rv) chk({tag, "_req_addr"}, 64'(req_addr), 64'(addr));
      chk({tag, "_valid_enq"}, 64'(valid_enq), 64'(ve));
      if (ve) chk({tag, "_data_enq"}, data_enq, 64'(ent(pc)));
   endtask

   initial begin
      tbl[0] = mkv(1, 1, 32'h0, 0, 32'h0);
      tbl[1] = mkv(1, 0, 32'h0, 0, 32'h0);
      tbl[2] = mkv(1, 1, 32'h4, 1, 32'h0);
      tbl[3] = mkv(1, 0, 32'h0, 0, 32'h0);
      tbl[4] = mkv(1, 1, 32'h8, 1, 32'h4);
      tbl[5] = mkv(1, 0, 32'h0, 0, 32'h0);
      tbl[6] = mkv(1, 1, 32'hC, 1, 32'h8);
      tbl[7] = mkv(1, 0, 32'h0, 0, 32'h0);

      // Steady state, 1-cycle memory, queue never full.
      do_reset();
      exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      exp_enq_q  = '{ent(32'h0), ent(32'h4), ent(32'h8)};
      b_cap = 1;
      for (int i = 0; i < 8; i++) begin
         ready_enq = tbl[i].rdy;
         cyc_chk("tbl", tbl[i].rv, tbl[i].addr, tbl[i].ve, tbl[i].data.pc);
         tick();
      end
      b_cap = 0;
      chk("wrap_b_cnt", 64'(b_q.size() >= 2), 64'd1);
      if (b_q.size() >= 2) begin
         chk("wrap_b_first", 64'(b_q[0]), 64'hFFFF_FFFC);
         chk("wrap_b_second", 64'(b_q[1]), 64'h0);
      end
      drained();

      // Queue back-pressure for 10 cycles after the first response.
      do_reset();
      exp_addr_q = '{32'h0, 32'h4, 32'h8};
      exp_enq_q  = '{ent(32'h0), ent(32'h4)};
      ready_enq = 0;
      cyc_chk("bp0", 1, 32'h0, 0, 0); tick();
      cyc_chk("bp1", 0, 0, 0, 0);     tick();
      for (int i = 0; i < 10; i++) begin
         cyc_chk("bp_hold", 0, 0, 1, 32'h0);
         tick();
      end
      ready_enq = 1;
      cyc_chk("bp12", 1, 32'h4, 1, 32'h0); tick();
      cyc_chk("bp13", 0, 0, 0, 0);         tick();
      cyc_chk("bp14", 1, 32'h8, 1, 32'h4); tick();
      drained();

      // Redirect with held entry (flush), then redirect in WAIT with no response (DROP).
      do_reset();
      mem_auto = 0;
      exp_addr_q = '{32'h0, 32'h500, 32'h1000, 32'h1004};
      exp_enq_q  = '{ent(32'h1000)};
      ready_enq = 0;
      cyc_chk("rd0", 1, 32'h0, 0, 0); tick();
      man_v = 1; man_instr = f(32'h0);
      cyc_chk("rd1", 0, 0, 0, 0); tick();
      man_v = 0; redirect_valid = 1; redirect_pc = 32'h0000_0502;
      cyc_chk("rd2", 0, 0, 1, 32'h0); tick();
      redirect_valid = 0; ready_enq = 1;
      cyc_chk("rd3", 1, 32'h500, 0, 0); tick();
      redirect_valid = 1; redirect_pc = 32'h0000_1002;
      cyc_chk("rd4", 0, 0, 0, 0); tick();
      redirect_valid = 0; man_v = 1; man_instr = f(32'h500);
      cyc_chk("rd5_drop", 0, 0, 0, 0); tick();
      man_v = 0;
      cyc_chk("rd6", 1, 32'h1000, 0, 0); tick();
      man_v = 1; man_instr = f(32'h1000);
      cyc_chk("rd7", 0, 0, 0, 0); tick();
      man_v = 0;
      cyc_chk("rd8", 1, 32'h1004, 1, 32'h1000); tick();
      drained();

      // Redirect coincident with the response: no DROP, request next cycle.
      do_reset();
      mem_auto = 0;
      exp_addr_q = '{32'h0, 32'h2000, 32'h2004};
      exp_enq_q  = '{ent(32'h2000)};
      cyc_chk("rc0", 1, 32'h0, 0, 0); tick();
      man_v = 1; man_instr = f(32'h0); redirect_valid = 1; redirect_pc = 32'h0000_2000;
      cyc_chk("rc1", 0, 0, 0, 0); tick();
      man_v = 0; redirect_valid = 0;
      cyc_chk("rc2", 1, 32'h2000, 0, 0); tick();
      man_v = 1; man_instr = f(32'h2000);
      cyc_chk("rc3", 0, 0, 0, 0); tick();
      man_v = 0;
      cyc_chk("rc4", 1, 32'h2004, 1, 32'h2000); tick();
      drained();

      // Reset asserted while waiting on a response.
      do_reset();
      exp_addr_q = '{32'h0, 32'h0, 32'h4};
      exp_enq_q  = '{ent(32'h0)};
      cyc_chk("mr0", 1, 32'h0, 0, 0); tick();
      rst = 1;
      smp();
      chk("mr1_req_valid", 64'(req_valid), 64'd0);
      chk("mr1_valid_enq", 64'(valid_enq), 64'd0);
      chk("mr1_req_addr", 64'(req_addr), 64'd0);
      tick();
      rst = 0;
      cyc_chk("mr2", 1, 32'h0, 0, 0); tick();
      cyc_chk("mr3", 0, 0, 0, 0);     tick();
      cyc_chk("mr4", 1, 32'h4, 1, 32'h0); tick();
      drained();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
